mem_model_rw: RTL and testbench

- Parametrised simulation memory model used as the instruction/data backing store for the core in top-level benches.
- Serves single-word reads over the RRdy/RVld handshake with configurable read latency.
- Adds a byte-strobed write port and an out-of-range error flag.
- Array is exposed as `mem` so benches preload it hierarchically, e.g. from pattern files.

---
 rtl/mem_model_rw_if.sv | 39 +++
 rtl/mem_model_rw.sv | 161 ++++++++++++++++
 tb/tb_mem_model_rw.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_model_rw_if.sv
// -----------------------------------------------------------------------------
// mem_model_rw_if
//   Bus bundle for the simulation memory model: one read channel
//   (RRdy/RAddr -> RVld/RData/RErr) and one byte-strobed write channel
//   (WEn/WAddr/WData/WStrb -> WAck).
//
//   Parameters
//     DATA_W : data word width in bits (multiple of 8)
//     AW_IN  : width of the RAddr/WAddr word-address buses
//
//   Modports
//     master : drives requests, receives responses (core / bench side)
//     slave  : receives requests, drives responses (memory side)
// -----------------------------------------------------------------------------
interface mem_model_rw_if #(
    parameter int DATA_W = 32,
    parameter int AW_IN  = 32
);
    logic                  RRdy;
    logic [AW_IN-1:0]      RAddr;
    logic                  RVld;
    logic [DATA_W-1:0]     RData;
    logic                  RErr;
    logic                  WEn;
    logic [AW_IN-1:0]      WAddr;
    logic [DATA_W-1:0]     WData;
    logic [DATA_W/8-1:0]   WStrb;
    logic                  WAck;

    modport master (
        output RRdy, RAddr, WEn, WAddr, WData, WStrb,
        input  RVld, RData, RErr, WAck
    );

    modport slave (
        input  RRdy, RAddr, WEn, WAddr, WData, WStrb,
        output RVld, RData, RErr, WAck
    );
endinterface

// File: rtl/mem_model_rw.sv
// -----------------------------------------------------------------------------
// mem_model_rw
//   Parametrised memory model used as instruction/data backing store.
//   Single-word reads with a configurable latency over the RRdy/RVld
//   handshake, an always-accepted byte-strobed write port, and an
//   out-of-range flag on reads. The storage array is named `mem` so that
//   benches can preload it hierarchically; it is never cleared by reset.
//
//   Parameters
//     DATA_W : word width (multiple of 8)
//     ADDR_W : word-address width, DEPTH = 2**ADDR_W
//     RD_LAT : cycles from request acceptance to RVld (1..15)
//     AW_IN  : width of RAddr/WAddr; bits above ADDR_W-1 must be zero
//
//   Ports
//     clk  : clock, rising edge
//     rstn : asynchronous active-low reset
//     bus  : mem_model_rw_if.slave (read and write channels)
// -----------------------------------------------------------------------------
module mem_model_rw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1,
    parameter int AW_IN  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    mem_model_rw_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Backing store; no reset so preloaded contents survive rstn.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_cap_data;
    logic              r_cap_err;
    logic              r_rvld;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rerr;
    logic              r_wack;

    logic              w_raddr_oor;
    logic              w_waddr_oor;
    logic [ADDR_W-1:0] w_raddr_idx;
    logic [ADDR_W-1:0] w_waddr_idx;
    logic [DATA_W-1:0] w_bit_mask;
    logic              w_wr_commit;

    assign w_raddr_idx = bus.RAddr[ADDR_W-1:0];
    assign w_waddr_idx = bus.WAddr[ADDR_W-1:0];

    // Any address bit above the array range marks the access out of range;
    // there is no wrap-around onto the low addresses.
    generate
        if (AW_IN > ADDR_W) begin : g_range
            assign w_raddr_oor = |bus.RAddr[AW_IN-1:ADDR_W];
            assign w_waddr_oor = |bus.WAddr[AW_IN-1:ADDR_W];
        end else begin : g_no_range
            assign w_raddr_oor = 1'b0;
            assign w_waddr_oor = 1'b0;
        end
    endgenerate

    // Expand byte strobes into a per-bit merge mask.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign w_bit_mask[8*gi +: 8] = {8{bus.WStrb[gi]}};
        end
    endgenerate

    assign w_wr_commit = bus.WEn && !w_waddr_oor;

    // Write port: read-modify-write merge keeps unstrobed bytes intact.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            mem[w_waddr_idx] <= (mem[w_waddr_idx] & ~w_bit_mask)
                              | (bus.WData & w_bit_mask);
        end
    end

    // Write acknowledge follows every write by one cycle, in range or not.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wack <= 1'b0;
        end else begin
            r_wack <= bus.WEn;
        end
    end

    // Read FSM. The array is sampled at the acceptance edge, so a write at
    // that same edge (or during WAIT) is not visible in this response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_cap_data <= '0;
            r_cap_err  <= 1'b0;
            r_rvld     <= 1'b0;
            r_rdata    <= '0;
            r_rerr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.RRdy) begin
                        if (RD_LAT == 1) begin
                            r_state <= RESP;
                            r_rvld  <= 1'b1;
                            r_rdata <= w_raddr_oor ? '0 : mem[w_raddr_idx];
                            r_rerr  <= w_raddr_oor;
                        end else begin
                            r_state    <= WAIT;
                            r_cnt      <= 4'(RD_LAT - 1);
                            r_cap_data <= w_raddr_oor ? '0 : mem[w_raddr_idx];
                            r_cap_err  <= w_raddr_oor;
                        end
                    end
                end
                WAIT: begin
                    // RRdy is ignored here; the request is already captured.
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        r_cnt   <= 4'd0;
                        r_rvld  <= 1'b1;
                        r_rdata <= r_cap_data;
                        r_rerr  <= r_cap_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // One-cycle response pulse; data bus returns to zero.
                    r_state <= IDLE;
                    r_rvld  <= 1'b0;
                    r_rdata <= '0;
                    r_rerr  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_rvld  <= 1'b0;
                    r_rdata <= '0;
                    r_rerr  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RVld  = r_rvld;
    assign bus.RData = r_rdata;
    assign bus.RErr  = r_rerr;
    assign bus.WAck  = r_wack;

endmodule

// File: tb/tb_mem_model_rw.sv
// -----------------------------------------------------------------------------
// tb_mem_model_rw
//   Two memory models (read latency 1 and 3) share the same stimulus.
//   A transaction-level reference model predicts every output cycle by cycle:
//   a read accepted at edge N answers after edge N+LAT-1 with the array
//   contents seen at edge N, and the next acceptance is possible at N+LAT+1.
//   Directed table reads and hand sequences check against fixed constants.
// -----------------------------------------------------------------------------
module tb_mem_model_rw;
    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int AWI = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        rrdy;
    logic [31:0] raddr;
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic [1:0]       rvld_o;
    logic [1:0]       rerr_o;
    logic [1:0]       wack_o;
    logic [1:0][31:0] rdata_o;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 3;
            mem_model_rw_if #(.DATA_W(DW), .AW_IN(AWI)) bus ();
            assign bus.RRdy  = rrdy;
            assign bus.RAddr = raddr;
            assign bus.WEn   = wen;
            assign bus.WAddr = waddr;
            assign bus.WData = wdata;
            assign bus.WStrb = wstrb;
            assign rvld_o[gi]  = bus.RVld;
            assign rdata_o[gi] = bus.RData;
            assign rerr_o[gi]  = bus.RErr;
            assign wack_o[gi]  = bus.WAck;
            mem_model_rw #(
                .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .AW_IN(AWI)
            ) u_dut (
                .clk  (clk),
                .rstn (rstn),
                .bus  (bus)
            );
        end
    endgenerate

    // ---------------- reference model state ----------------
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    longint      cyc    = 0;
    longint      next_free [2];
    longint      resp_edge [2];
    logic        pend      [2];
    logic [31:0] snap_d    [2];
    logic        snap_e    [2];
    logic        got       [2];
    logic [31:0] got_d     [2];
    logic        got_e     [2];
    int          pulses    [2];
    logic [31:0] ref_mem [0:65535];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } rd_vec_t;
    rd_vec_t tbl [7];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        g_dut[0].u_dut.mem[a] = v;
        g_dut[1].u_dut.mem[a] = v;
        ref_mem[a] = v;
    endtask

    // One clock edge: predict outputs from the inputs seen at that edge,
    // compare, then apply the write to the reference array.
    task automatic step();
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        logic        ew;
        logic        oor;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                pend[d] = 1'b0;
                next_free[d] = 0;
                ev = 1'b0; ed = '0; ee = 1'b0; ew = 1'b0;
            end else begin
                if (rrdy && cyc >= next_free[d]) begin
                    oor = (raddr[31:16] != 16'h0);
                    snap_d[d]    = oor ? 32'h0 : ref_mem[raddr[15:0]];
                    snap_e[d]    = oor;
                    resp_edge[d] = cyc + lat_of(d) - 1;
                    next_free[d] = cyc + lat_of(d) + 1;
                    pend[d]      = 1'b1;
                end
                ev = pend[d] && (resp_edge[d] == cyc);
                if (ev) pend[d] = 1'b0;
                ed = ev ? snap_d[d] : 32'h0;
                ee = ev && snap_e[d];
                ew = wen;
            end
            chk($sformatf("d%0d RVld cyc%0d", d, cyc),  32'(rvld_o[d]), 32'(ev));
            chk($sformatf("d%0d RData cyc%0d", d, cyc), rdata_o[d], ed);
            chk($sformatf("d%0d RErr cyc%0d", d, cyc),  32'(rerr_o[d]), 32'(ee));
            chk($sformatf("d%0d WAck cyc%0d", d, cyc),  32'(wack_o[d]), 32'(ew));
            if (rvld_o[d]) begin
                pulses[d]++;
                if (!got[d]) begin
                    got[d]   = 1'b1;
                    got_d[d] = rdata_o[d];
                    got_e[d] = rerr_o[d];
                end
            end
        end
        if (rstn && wen && waddr[31:16] == 16'h0) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) ref_mem[waddr[15:0]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endtask

    // Issue one read on both models, hold RRdy until both answered, and
    // compare the first response of each against fixed expectations.
    // Any write set up by the caller is applied on the first edge only.
    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_e, input string tag);
        got[0] = 1'b0;
        got[1] = 1'b0;
        rrdy  = 1'b1;
        raddr = a;
        for (int k = 0; k < 40 && !(got[0] && got[1]); k++) begin
            step();
            wen = 1'b0;
        end
        rrdy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (!got[d]) begin
                chk($sformatf("%s d%0d timeout", tag, d), 32'h0, 32'h1);
            end else begin
                chk($sformatf("%s d%0d data", tag, d), got_d[d], exp_d);
                chk($sformatf("%s d%0d err", tag, d), 32'(got_e[d]), 32'(exp_e));
            end
        end
        $display("read %s addr=%h d0=%h/%b d1=%h/%b", tag, a,
                 got_d[0], got_e[0], got_d[1], got_e[1]);
        repeat (4) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; rrdy = 1'b0; raddr = '0;
        wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; next_free[d] = 0; resp_edge[d] = 0;
            got[d] = 1'b0; pulses[d] = 0; got_d[d] = '0; got_e[d] = 1'b0;
            snap_d[d] = '0; snap_e[d] = 1'b0;
        end
        for (int i = 0; i < 32; i++) preload(i, 32'h5A00_0000 | 32'(i));
        preload(0, 32'h0BAD_F00D);
        preload(4, 32'hDEAD_BEEF);
        preload(8, 32'hAABB_CCDD);
        preload(65535, 32'hCAFE_BABE);

        tbl[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h0BAD_F00D, 1'b0};
        tbl[2] = '{32'h0000_FFFF, 32'hCAFE_BABE, 1'b0};
        tbl[3] = '{32'h0001_0000, 32'h0000_0000, 1'b1};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'h0000_001F, 32'h5A00_001F, 1'b0};
        tbl[6] = '{32'h8000_0008, 32'h0000_0000, 1'b1};

        // Reset state
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset d%0d RVld", d),  32'(rvld_o[d]), 32'h0);
            chk($sformatf("reset d%0d RData", d), rdata_o[d], 32'h0);
            chk($sformatf("reset d%0d RErr", d),  32'(rerr_o[d]), 32'h0);
            chk($sformatf("reset d%0d WAck", d),  32'(wack_o[d]), 32'h0);
        end
        rstn = 1'b1;
        step();

        // Table-driven reads, including range boundaries
        for (int i = 0; i < 7; i++) begin
            do_read(tbl[i].addr, tbl[i].data, tbl[i].err, $sformatf("tbl%0d", i));
        end

        // RRdy held high: latency 1 answers every other cycle, latency 3
        // every fourth cycle.
        pulses[0] = 0;
        pulses[1] = 0;
        rrdy  = 1'b1;
        raddr = 32'h4;
        repeat (12) step();
        rrdy = 1'b0;
        chk("throughput d0 pulses", 32'(pulses[0]), 32'd6);
        chk("throughput d1 pulses", 32'(pulses[1]), 32'd3);
        $display("throughput pulses d0=%0d d1=%0d", pulses[0], pulses[1]);
        repeat (4) step();

        // Strobed write merge
        wen = 1'b1; waddr = 32'h8; wdata = 32'h1122_3344; wstrb = 4'b0101;
        step();
        wen = 1'b0;
        chk("strobe wr d0 WAck", 32'(wack_o[0]), 32'h1);
        chk("strobe wr d1 WAck", 32'(wack_o[1]), 32'h1);
        step();
        chk("strobe wr d0 WAck drop", 32'(wack_o[0]), 32'h0);
        $display("write addr=00000008 data=11223344 strb=0101");
        do_read(32'h8, 32'hAA22_CC44, 1'b0, "strobe");

        // Same-edge read acceptance and write: read sees the old word
        wen = 1'b1; waddr = 32'h8; wdata = 32'h0; wstrb = 4'hF;
        do_read(32'h8, 32'hAA22_CC44, 1'b0, "same-edge");
        do_read(32'h8, 32'h0000_0000, 1'b0, "after-write");

        // Out-of-range write: acknowledged, memory untouched
        wen = 1'b1; waddr = 32'h0001_0000; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        step();
        wen = 1'b0;
        chk("oor wr d0 WAck", 32'(wack_o[0]), 32'h1);
        chk("oor wr d1 WAck", 32'(wack_o[1]), 32'h1);
        $display("write addr=00010000 data=ffffffff strb=1111");
        do_read(32'h0, 32'h0BAD_F00D, 1'b0, "oor-wr-mem0");

        // Reset while the latency-3 model waits; write just before persists
        wen = 1'b1; waddr = 32'd20; wdata = 32'h600D_CAFE; wstrb = 4'hF;
        rrdy = 1'b1; raddr = 32'h4;
        step();
        rrdy = 1'b0; wen = 1'b0;
        rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("async rst d%0d RVld", d),  32'(rvld_o[d]), 32'h0);
            chk($sformatf("async rst d%0d RData", d), rdata_o[d], 32'h0);
            chk($sformatf("async rst d%0d WAck", d),  32'(wack_o[d]), 32'h0);
        end
        pulses[0] = 0;
        pulses[1] = 0;
        repeat (3) step();
        rstn = 1'b1;
        repeat (6) step();
        chk("dropped read d1 pulses", 32'(pulses[1]), 32'h0);
        chk("dropped read d0 pulses", 32'(pulses[0]), 32'h0);
        $display("reset mid-read pulses d0=%0d d1=%0d", pulses[0], pulses[1]);
        do_read(32'd20, 32'h600D_CAFE, 1'b0, "post-rst-wr");
        do_read(32'h4, 32'hDEAD_BEEF, 1'b0, "post-rst-preload");

        // Randomised traffic against the reference model
        pulses[0] = 0;
        pulses[1] = 0;
        for (int c = 0; c < 500; c++) begin
            rrdy  = ($urandom_range(0, 9) < 7);
            raddr = ($urandom_range(0, 7) == 0) ? {16'($urandom_range(1, 65535)), 16'($urandom)}
                                                : 32'($urandom_range(0, 31));
            wen   = ($urandom_range(0, 1) == 1);
            waddr = ($urandom_range(0, 7) == 0) ? {16'($urandom_range(1, 65535)), 16'($urandom)}
                                                : 32'($urandom_range(0, 31));
            wdata = $urandom;
            wstrb = 4'($urandom_range(0, 15));
            step();
        end
        rrdy = 1'b0;
        wen  = 1'b0;
        repeat (5) step();
        $display("random phase responses d0=%0d d1=%0d", pulses[0], pulses[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
